// File: rtl/idli_sqi_fetch_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_fetch_m
//
// Instruction fetch sequencer. Captures the current PC from the PC block's
// nibble-serial rotating slice (LSB nibble first), pulses the PC increment
// strobe for one full rotation, runs an SQI read of one 16b instruction from
// the external SRAM and presents it to decode behind a valid/ready handshake.
//
// Ports:
//   i_fe_gck      clock (same gated clock as the PC block)
//   i_fe_rst      asynchronous active-high reset
//   i_fe_en       fetch enable, sampled only in IDLE
//   i_fe_pc       4b PC slice; phase 0 carries PC[3:0]
//   o_fe_pc_inc   increment strobe to the PC block (high for the 4 CAPT cycles)
//   o_sqi_cs_n    SRAM chip select, active-low
//   o_sqi_sck_en  SQI clock enable
//   o_sqi_oe      1 = drive o_sqi_d onto the pads
//   o_sqi_d       SQI data out (0 when not driving)
//   i_sqi_d       SQI data in, sampled only in DATA
//   o_fe_instr    fetched instruction (big-endian: first nibble is [15:12])
//   o_fe_vld      instruction valid
//   i_fe_rdy      decode accepts the instruction
//   o_fe_state    current FSM state, for observation only
//
// Handshake: a transfer happens on every rising clock edge where o_fe_vld and
// i_fe_rdy are both high. o_fe_vld, once raised, stays high with o_fe_instr
// stable until that transfer, and drops on the following cycle. i_fe_rdy is
// ignored while o_fe_vld is low.
// -----------------------------------------------------------------------------
module idli_sqi_fetch_m #(
    parameter logic [7:0]  CMD_READ  = 8'h03,
    parameter int unsigned DUMMY_CYC = 2
) (
    input  logic        i_fe_gck,
    input  logic        i_fe_rst,
    input  logic        i_fe_en,
    input  logic [3:0]  i_fe_pc,
    output logic        o_fe_pc_inc,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic        o_sqi_oe,
    output logic [3:0]  o_sqi_d,
    input  logic [3:0]  i_sqi_d,
    output logic [15:0] o_fe_instr,
    output logic        o_fe_vld,
    input  logic        i_fe_rdy,
    output logic [2:0]  o_fe_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CAPT  = 3'd1,
        CMD   = 3'd2,
        ADDR  = 3'd3,
        DUMMY = 3'd4,
        DATA  = 3'd5,
        HOLD  = 3'd6
    } state_t;

    // Last value of cnt_q in DUMMY. Unused when DUMMY_CYC is 0 (ADDR goes
    // straight to DATA).
    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYC - 1);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  cnt_q;
    logic [7:0]  cnt_d;
    logic [1:0]  phase_q;
    logic [15:0] addr_q;
    logic [15:0] instr_q;
    logic        vld_q;
    logic [23:0] addr_byte;
    logic        on_bus;

    // -------------------------------------------------------------------------
    // State register and datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge i_fe_gck or posedge i_fe_rst) begin
        if (i_fe_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            addr_q  <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            // Free-running so it stays locked to the PC block's rotation;
            // both blocks leave reset on the same edge.
            phase_q <= phase_q + 2'd1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vld_q   <= (state_d == HOLD);
            // PC arrives LSB nibble first, so shift in from the top.
            if (state_q == CAPT) begin
                addr_q <= {i_fe_pc, addr_q[15:4]};
            end
            // SRAM returns MSB nibble first, so shift in from the bottom.
            if (state_q == DATA) begin
                instr_q <= {instr_q[11:0], i_sqi_d};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // Entering CAPT on phase 3 makes the first CAPT cycle see PC[3:0].
                if (i_fe_en && (phase_q == 2'd3)) begin
                    state_d = CAPT;
                end
            end
            CAPT: begin
                if (cnt_q == 8'd3) begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
            end
            CMD: begin
                if (cnt_q == 8'd1) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                end
            end
            ADDR: begin
                if (cnt_q == 8'd5) begin
                    state_d = (DUMMY_CYC == 0) ? DATA : DUMMY;
                    cnt_d   = '0;
                end
            end
            DUMMY: begin
                if (cnt_q == DUMMY_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (cnt_q == 8'd3) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (i_fe_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from registered state only, so async reset forces them
    // to their idle values without any clock edge)
    // -------------------------------------------------------------------------
    // Instructions are 16b wide, so the byte address is the PC shifted left.
    assign addr_byte = {7'b0, addr_q, 1'b0};
    assign on_bus    = (state_q == CMD) || (state_q == ADDR) ||
                       (state_q == DUMMY) || (state_q == DATA);

    always_comb begin
        o_sqi_d = 4'h0;
        case (state_q)
            CMD: begin
                o_sqi_d = cnt_q[0] ? CMD_READ[3:0] : CMD_READ[7:4];
            end
            ADDR: begin
                case (cnt_q[2:0])
                    3'd0:    o_sqi_d = addr_byte[23:20];
                    3'd1:    o_sqi_d = addr_byte[19:16];
                    3'd2:    o_sqi_d = addr_byte[15:12];
                    3'd3:    o_sqi_d = addr_byte[11:8];
                    3'd4:    o_sqi_d = addr_byte[7:4];
                    3'd5:    o_sqi_d = addr_byte[3:0];
                    default: o_sqi_d = 4'h0;
                endcase
            end
            default: o_sqi_d = 4'h0;
        endcase
    end

    assign o_fe_pc_inc  = (state_q == CAPT);
    assign o_sqi_cs_n   = ~on_bus;
    assign o_sqi_sck_en = on_bus;
    assign o_sqi_oe     = (state_q == CMD) || (state_q == ADDR);
    assign o_fe_instr   = instr_q;
    assign o_fe_vld     = vld_q;
    assign o_fe_state   = state_q;

endmodule

// File: tb/tb_idli_sqi_fetch_m.sv
// -----------------------------------------------------------------------------
// tb_idli_sqi_fetch_m
//
// Bench for idli_sqi_fetch_m. Contains a small nibble-serial PC block model
// and an SQI SRAM responder; expected instructions and byte addresses are
// queued when a fetch is launched and popped when o_fe_vld appears.
// -----------------------------------------------------------------------------
module tb_idli_sqi_fetch_m;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        i_fe_en;
    logic [3:0]  pc_slice;
    logic        o_fe_pc_inc;
    logic        o_sqi_cs_n;
    logic        o_sqi_sck_en;
    logic        o_sqi_oe;
    logic [3:0]  o_sqi_d;
    logic [3:0]  i_sqi_d;
    logic [15:0] o_fe_instr;
    logic        o_fe_vld;
    logic        i_fe_rdy;
    logic [2:0]  fe_state;

    idli_sqi_fetch_m dut (
        .i_fe_gck     (clk),
        .i_fe_rst     (rst),
        .i_fe_en      (i_fe_en),
        .i_fe_pc      (pc_slice),
        .o_fe_pc_inc  (o_fe_pc_inc),
        .o_sqi_cs_n   (o_sqi_cs_n),
        .o_sqi_sck_en (o_sqi_sck_en),
        .o_sqi_oe     (o_sqi_oe),
        .o_sqi_d      (o_sqi_d),
        .i_sqi_d      (i_sqi_d),
        .o_fe_instr   (o_fe_instr),
        .o_fe_vld     (o_fe_vld),
        .i_fe_rdy     (i_fe_rdy),
        .o_fe_state   (fe_state)
    );

    localparam logic [2:0]  ST_IDLE = 3'd0;
    localparam logic [2:0]  ST_ADDR = 3'd3;
    // {inc, cs_n, sck_en, oe, d[3:0], instr[15:0], vld}
    localparam logic [24:0] RST_VEC = 25'h080_0000;
    wire [24:0] outs_vec = {o_fe_pc_inc, o_sqi_cs_n, o_sqi_sck_en, o_sqi_oe,
                            o_sqi_d, o_fe_instr, o_fe_vld};

    // ---------------- PC block model ----------------
    // 16b PC rotated out one nibble per cycle; increments by one only when the
    // strobe is held across a full phase 0..3 rotation.
    logic [15:0] pc_q;
    logic [1:0]  ph;
    logic [2:0]  inc_run;
    logic        pc_load;
    logic [15:0] pc_load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            ph      <= '0;
            inc_run <= '0;
        end else begin
            ph <= ph + 2'd1;
            if (pc_load) pc_q <= pc_load_val;
            else if (o_fe_pc_inc && ph == 2'd3 && inc_run == 3'd3) pc_q <= pc_q + 16'd1;
            if (!o_fe_pc_inc || ph == 2'd3) inc_run <= '0;
            else inc_run <= inc_run + 3'd1;
        end
    end
    assign pc_slice = pc_q[{ph, 2'b00} +: 4];

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    logic [23:0] exp_addr_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- SQI SRAM responder / bus monitor ----------------
    logic [15:0] sram_word;
    logic [7:0]  cmd_cap;
    logic [23:0] adr_cap;
    int          sqi_cnt;
    int          sqi_len;
    int          bus_viol;
    int          inc_total;
    bit          inc_prev;

    initial begin
        sqi_cnt   = 0;
        sqi_len   = 0;
        bus_viol  = 0;
        inc_total = 0;
        inc_prev  = 1'b0;
        cmd_cap   = '0;
        adr_cap   = '0;
        i_sqi_d   = '0;
        forever begin
            @(negedge clk);
            if (!o_sqi_cs_n) begin
                // cycle index: 0-1 command, 2-7 address, 8-9 dummy, 10-13 data
                if (!o_sqi_sck_en) bus_viol++;
                if (o_sqi_oe !== (sqi_cnt < 8)) bus_viol++;
                if (sqi_cnt < 2) cmd_cap = {cmd_cap[3:0], o_sqi_d};
                else if (sqi_cnt < 8) adr_cap = {adr_cap[19:0], o_sqi_d};
                if (sqi_cnt >= 10 && sqi_cnt < 14) i_sqi_d = sram_word[4*(13-sqi_cnt) +: 4];
                else i_sqi_d = 4'($urandom_range(0, 15));
                sqi_cnt++;
            end else begin
                if (sqi_cnt != 0) sqi_len = sqi_cnt;
                sqi_cnt = 0;
                i_sqi_d = 4'($urandom_range(0, 15));
                if (o_sqi_sck_en || o_sqi_oe) bus_viol++;
            end
            if (!o_sqi_oe && o_sqi_d !== 4'h0) bus_viol++;
            if (o_fe_pc_inc) inc_total++;
            inc_prev = o_fe_pc_inc;
        end
    end

    // ---------------- driver task ----------------
    // en_phase < 0 raises i_fe_en immediately, otherwise at that phase.
    task automatic do_fetch(input logic [15:0] word, input int en_phase,
                            input bit rdy_early, input int hold_cyc);
        int          t_en;
        int          t_capt;
        int          exp_delay;
        int          base_inc;
        bit          seen;
        logic [15:0] exp_instr;
        exp_q.push_back(word);
        exp_addr_q.push_back({7'b0, exp_pc, 1'b0});
        sram_word = word;
        base_inc  = inc_total;
        if (en_phase >= 0) begin
            for (int i = 0; i < 8 && int'(ph) != en_phase; i++) @(negedge clk);
        end
        t_en      = cyc;
        exp_delay = 4 - int'(ph);
        i_fe_en   = 1'b1;
        i_fe_rdy  = rdy_early;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_fe_pc_inc) begin seen = 1'b1; break; end
        end
        chk("capt_start", 32'(seen), 32'd1);
        chk("capt_delay", cyc - t_en, exp_delay);
        chk("capt_phase", 32'(ph), 32'd0);
        t_capt  = cyc;
        i_fe_en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_fe_vld) begin seen = 1'b1; break; end
        end
        chk("vld_seen", 32'(seen), 32'd1);
        chk("vld_latency", cyc - t_capt, 32'd18);
        exp_instr = exp_q.pop_front();
        chk("instr", 32'(o_fe_instr), 32'(exp_instr));
        chk("sqi_cmd", 32'(cmd_cap), 32'h03);
        chk("sqi_addr", 32'(adr_cap), 32'(exp_addr_q.pop_front()));
        for (int i = 0; i < hold_cyc; i++) begin
            @(negedge clk);
            chk("hold_vld", 32'(o_fe_vld), 32'd1);
            chk("hold_instr", 32'(o_fe_instr), 32'(exp_instr));
            chk("hold_cs_n", 32'(o_sqi_cs_n), 32'd1);
            chk("hold_inc", 32'(o_fe_pc_inc), 32'd0);
        end
        i_fe_rdy = 1'b1;
        @(negedge clk);
        chk("vld_fall", 32'(o_fe_vld), 32'd0);
        i_fe_rdy = 1'b0;
        chk("sqi_len", sqi_len, 32'd14);
        chk("inc_cycles", inc_total - base_inc, 32'd4);
        exp_pc = exp_pc + 16'd1;
        chk("pc_after", 32'(pc_q), 32'(exp_pc));
    endtask

    task automatic load_pc(input logic [15:0] val);
        pc_load_val = val;
        pc_load     = 1'b1;
        exp_pc      = val;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        rst         = 1'b1;
        i_fe_en     = 1'b0;
        i_fe_rdy    = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        exp_pc      = '0;
        sram_word   = '0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'(outs_vec), 32'(RST_VEC));
        chk("rst_state", 32'(fe_state), 32'(ST_IDLE));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outputs", 32'(outs_vec), 32'(RST_VEC));

        do_fetch(16'hA53C, -1, 1'b0, 0);          // PC 0
        load_pc(16'h8001);
        do_fetch(16'h1234, -1, 1'b1, 0);          // rdy high before valid
        load_pc(16'hFFFF);
        do_fetch(16'hBEEF, -1, 1'b0, 0);          // PC wraps to 0
        do_fetch(16'h5AF0, -1, 1'b0, 10);         // decode stalls 10 cycles
        do_fetch(16'h0F0F, 1, 1'b0, 0);           // enable raised at phase 1

        // reset in the middle of the address phase
        i_fe_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!o_sqi_cs_n) begin seen = 1'b1; break; end
        end
        chk("abort_bus_start", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        chk("abort_in_addr", 32'(fe_state), 32'(ST_ADDR));
        rst     = 1'b1;
        i_fe_en = 1'b0;
        #1;
        chk("abort_outputs", 32'(outs_vec), 32'(RST_VEC));
        chk("abort_state", 32'(fe_state), 32'(ST_IDLE));
        @(negedge clk);
        rst    = 1'b0;
        exp_pc = '0;
        @(negedge clk);
        do_fetch(16'hC3D2, -1, 1'b0, 0);          // restart from PC 0

        repeat (4) @(negedge clk);
        chk("bus_protocol", bus_viol, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/idli_sqi_fetch_m.md
# idli_sqi_fetch_m

Instruction fetch sequencer. It sits directly downstream of the PC block and consumes the PC's 4b-per-cycle rotating slice, LSB nibble first. It drives the increment strobe back into the PC and runs an SQI read to the external instruction SRAM. The fetched 16b instruction is presented to decode behind a valid/ready handshake.

## Interface
Parameters:
- `CMD_READ`, default 8'h03: SQI read opcode.
- `DUMMY_CYC`, default 2: dummy cycles between address and data.

Ports:
- `i_fe_gck`, in, 1: clock, the same gated clock as the PC block.
- `i_fe_rst`, in, 1: reset, asynchronous, active-high.
- `i_fe_en`, in, 1: fetch enable. Sampled only in IDLE.
- `i_fe_pc`, in, 4: current PC slice from the PC block's `o_pc`.
- `o_fe_pc_inc`, out, 1: increment strobe to the PC block's `i_pc_inc`.
- `o_sqi_cs_n`, out, 1: SRAM chip select, active-low.
- `o_sqi_sck_en`, out, 1: SQI clock enable.
- `o_sqi_oe`, out, 1: 1 = drive `o_sqi_d` onto the pads.
- `o_sqi_d`, out, 4: SQI data out.
- `i_sqi_d`, in, 4: SQI data in.
- `o_fe_instr`, out, 16: fetched instruction.
- `o_fe_vld`, out, 1: instruction valid.
- `i_fe_rdy`, in, 1: decode accepts the instruction.

## Operation
- `phase_q`, 2b, is a free-running counter. It is reset to 0 and increments every cycle with wrap 3->0. It tracks which PC nibble is on `i_fe_pc`: phase 0 = PC[3:0].
- Both blocks leave reset on the same edge, so phase and PC nibble stay aligned.
- States: IDLE, CAPT, CMD, ADDR, DUMMY, DATA, HOLD. A sub-counter `cnt_q` counts cycles within a state.
- IDLE:
  - Go to CAPT when `i_fe_en`=1 and `phase_q`=3.
  - Otherwise stay in IDLE.
- CAPT, 4 cycles, phases 0..3:
  - Shift `i_fe_pc` into a 16b address register, LSB nibble first.
  - Hold `o_fe_pc_inc`=1 for all 4 cycles, so the PC post-increments by exactly 1.
  - The captured value is the pre-increment PC.
- CMD, 2 cycles: `o_sqi_d` = `CMD_READ`[7:4], then `CMD_READ`[3:0].
- ADDR, 6 cycles:
  - Byte address A[23:0] = {7'b0, pc[15:0], 1'b0}.
  - Sent MSB nibble first: A[23:20] ... A[3:0].
- DUMMY, `DUMMY_CYC` cycles: `o_sqi_oe`=0.
- DATA, 4 cycles:
  - Shift `i_sqi_d` into the instruction register, MSB first.
  - The first nibble becomes `o_fe_instr`[15:12], i.e. big-endian: high byte at the even address.
- HOLD:
  - `o_fe_vld`=1.
  - On `i_fe_rdy`=1, go to IDLE.
- Output conditions:
  - `o_sqi_cs_n`=0 and `o_sqi_sck_en`=1 in CMD, ADDR, DUMMY and DATA only.
  - `o_sqi_oe`=1 in CMD and ADDR only.
  - `o_sqi_d`=0 when not driving.
- `i_fe_en` dropping after IDLE is ignored. The transaction and PC increment always complete.
- `o_fe_instr` holds its value from HOLD exit until the next DATA phase overwrites it.

## Timing
- Reset values:
  - Block state: IDLE, `phase_q`=0, all counters 0.
  - Outputs: `o_fe_pc_inc`=0, `o_sqi_cs_n`=1, `o_sqi_sck_en`=0, `o_sqi_oe`=0, `o_sqi_d`=0, `o_fe_instr`=0, `o_fe_vld`=0.
- Reset asserted mid-transaction returns to the reset values immediately (asynchronous). `cs_n` deasserts with no further edges. A partial PC increment is the PC block's concern; its reset also clears.
- Transaction length from CAPT entry to `o_fe_vld` rise: 4+2+6+`DUMMY_CYC`+4 = 18 cycles at defaults. `o_fe_vld` is registered and rises in the first HOLD cycle.
- Handshake:
  - Transfer occurs on the cycle with `o_fe_vld` & `i_fe_rdy`.
  - `o_fe_vld` falls on the next cycle.
  - IDLE then waits for `phase_q`=3. Back-to-back throughput is therefore one instruction per 20 cycles minimum, 4-cycle aligned.
- Boundaries:
  - `i_fe_rdy` high while not valid has no effect.
  - PC 16'hFFFF captures A=24'h01FFFE, and the PC wraps to 0.
  - `i_fe_en` high at phases 0..2 waits in IDLE until phase 3.
  - `i_sqi_d` is sampled only in DATA.

## Test plan
- Reset then `i_fe_en`=1 with PC=0, SRAM returning 8'hA5, 8'h3C:
  - `o_sqi_d` = 0,3 then 0,0,0,0,0,0.
  - `o_fe_instr`=16'hA53C, `o_fe_vld` 18 cycles after CAPT entry.
  - PC reads 1 afterwards.
- PC=16'h8001:
  - ADDR nibbles are 0,1,0,0,0,2, i.e. A=24'h010002.
  - PC becomes 16'h8002.
- PC=16'hFFFF: A=24'h01FFFE; PC wraps to 16'h0000.
- Hold `i_fe_rdy`=0 for 10 cycles in HOLD:
  - `o_fe_vld` and `o_fe_instr` are stable throughout.
  - `o_sqi_cs_n`=1 and `o_fe_pc_inc`=0 throughout.
  - Next CAPT starts at the first phase 0 after acceptance.
- Raise `i_fe_en` at `phase_q`=1: CAPT begins exactly 3 cycles later at phase 0. `o_fe_pc_inc` is high for exactly 4 cycles.
- Assert `i_fe_rst` during ADDR: all outputs return to reset values in the same cycle, and the next fetch restarts from CAPT.
